// File: rtl/seg7_pkg.sv
// Shared constants and types for the seg7 scan display slice.
// Segment codes are active-low gfedcba; the dp cathode is bit 7 of HEX_OUT.
package seg7_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit-slot timebase: slot counter, digit index, slot_tick and frame_end.
module seg7_scan_timer #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 4,
    localparam int unsigned CNT_W     = $clog2(SCAN_DIV),
    localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    output logic [IDX_W-1:0] digit_idx,
    output logic             slot_tick,
    output logic             frame_end
);

    logic [CNT_W-1:0] slot_cnt;

    always_comb begin
        slot_tick = (slot_cnt == CNT_W'(SCAN_DIV - 1));
        frame_end = slot_tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_tick) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed common-anode seven-segment driver with frame-aligned updates,
// PWM brightness and blanking. Optional leading-zero blanking: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] act_data, pend_data;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
    logic                    pending;
    logic [BRIGHT_W-1:0]     pwm_cnt;

    logic [IDX_W-1:0]        digit_idx;
    logic                    slot_tick, frame_end;

    nibble_t                 cur_nib;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   sel_on;
    logic                    lz_blank;
    logic                    digit_on;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic                    upper_zero;
`endif

    seg7_scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_timer (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .digit_idx (digit_idx),
        .slot_tick (slot_tick),
        .frame_end (frame_end)
    );

    assign upd_ready = !pending;

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        sel_on  = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = act_data[4*i +: 4];
                cur_dp    = act_dp[i];
                sel_on[i] = 1'b0;
            end
        end

        lz_blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; a digit blanks only while everything above it is also empty.
        upper_zero = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
            if (upper_zero && (digit_idx == IDX_W'(i)))
                lz_blank = 1'b1;
        end
`endif

        digit_on = !blank && !lz_blank && ((brightness == '1) || (pwm_cnt < brightness));
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            SEG_SELECT_OUT <= ANODE_OFF[NUM_DIGITS-1:0];
            HEX_OUT        <= SEG_OFF;
            act_data       <= '0;
            act_dp         <= '0;
            pend_data      <= '0;
            pend_dp        <= '0;
            pending        <= 1'b0;
            pwm_cnt        <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;

            // A transfer needs !pending, so it can never collide with the frame-end copy.
            if (frame_end && pending) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                pending  <= 1'b0;
            end else if (upd_valid && !pending) begin
                pend_data <= upd_data;
                pend_dp   <= upd_dp;
                pending   <= 1'b1;
            end

            // slot_tick still carries the old index, so blanking here hides the index change.
            if (slot_tick || !digit_on) begin
                SEG_SELECT_OUT <= ANODE_OFF[NUM_DIGITS-1:0];
                HEX_OUT        <= SEG_OFF;
            end else begin
                SEG_SELECT_OUT <= sel_on;
                HEX_OUT        <= {~cur_dp, SEG_LUT[cur_nib]};
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4, BRIGHT_W=2).
// Expected digit presentations are queued at stimulus time and popped by a negedge monitor.
module tb_seg7_scan_ctrl;

    logic        clk_sys    = 1'b0;
    logic        rst_n      = 1'b0;
    logic        upd_valid  = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_data   = '0;
    logic [3:0]  upd_dp     = '0;
    logic [1:0]  brightness = 2'd3;
    logic        blank      = 1'b0;
    logic [3:0]  SEG_SELECT_OUT;
    logic [7:0]  HEX_OUT;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] hex;
    } exp_t;

    exp_t        sb[$];
    logic        mon_en = 1'b0;
    int unsigned tcyc;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'hFF;
`else
    localparam logic [7:0] Z = 8'hC0;
`endif

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BRIGHT_W   (2)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_data       (upd_data),
        .upd_dp         (upd_dp),
        .brightness     (brightness),
        .blank          (blank),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    always #5 clk_sys = ~clk_sys;

    // Cycle number since reset release: cycle 0 is the first cycle with rst_n high.
    always @(posedge clk_sys) begin
        if (!rst_n) tcyc <= 0;
        else        tcyc <= tcyc + 1;
    end

    initial begin
        logic [3:0] prev_sel;
        exp_t       e;
        prev_sel = 4'hF;
        forever begin
            @(negedge clk_sys);
            if (mon_en && SEG_SELECT_OUT != prev_sel && SEG_SELECT_OUT != 4'hF) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL disp_unexpected: got sel=%h hex=%h, required no presentation", SEG_SELECT_OUT, HEX_OUT);
                end else begin
                    e = sb.pop_front();
                    if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex) begin
                        n_fail++;
                        $display("FAIL disp @cyc %0d: got sel=%h hex=%h, required sel=%h hex=%h",
                                 tcyc, SEG_SELECT_OUT, HEX_OUT, e.sel, e.hex);
                    end
                end
            end
            prev_sel = SEG_SELECT_OUT;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_at(input int unsigned c);
        int unsigned g = 0;
        while (tcyc != c && g < 300) begin
            step();
            g++;
        end
        if (tcyc != c) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_at: got cycle %0d, required %0d", tcyc, c);
        end
    endtask

    task automatic drain();
        int unsigned g = 0;
        while (sb.size() != 0 && g < 400) begin
            step();
            g++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // One frame of expectations, digit 0 first; 8'hFF means that slot stays dark.
    task automatic push4(input logic [7:0] h0, input logic [7:0] h1,
                         input logic [7:0] h2, input logic [7:0] h3);
        if (h0 != 8'hFF) sb.push_back('{4'hE, h0});
        if (h1 != 8'hFF) sb.push_back('{4'hD, h1});
        if (h2 != 8'hFF) sb.push_back('{4'hB, h2});
        if (h3 != 8'hFF) sb.push_back('{4'h7, h3});
    endtask

    task automatic count_on(input int unsigned n, output int unsigned cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk_sys);
            if (SEG_SELECT_OUT != 4'hF) cnt++;
        end
        step();
    endtask

    initial begin
        int unsigned cnt;
        int unsigned g;
        int unsigned k;
        logic [7:0]  hex_b [4];
        hex_b[0] = 8'hC6; hex_b[1] = 8'h90; hex_b[2] = 8'h80; hex_b[3] = 8'h78;

        // Reset state
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_sel", SEG_SELECT_OUT, 4'hF);
        chk("rst_hex", HEX_OUT, 8'hFF);
        chk("rst_ready", upd_ready, 1'b1);
        step();
        rst_n = 1'b1;
        push4(8'hC0, Z, Z, Z);
        push4(8'hC0, Z, Z, Z);
        mon_en = 1'b1;
        @(negedge clk_sys);
        chk("ready_after_rst", upd_ready, 1'b1);

        // Mid-frame update in frame 1, shown in frame 2
        wait_at(22);
        push4(8'h8E, 8'h88, 8'h24, 8'hF9);
        upd_data = 16'h12AF; upd_dp = 4'b0100; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        chk("ready_low_after_xfer", upd_ready, 1'b0);
        wait_at(31);
        chk("ready_low_at_frame_end", upd_ready, 1'b0);
        step();
        chk("ready_back", upd_ready, 1'b1);

        // Update A accepted, B held while pending, accepted after ready returns
        wait_at(34);
        push4(8'h82, 8'h92, 8'h99, 8'hB0);
        upd_data = 16'h3456; upd_dp = 4'b0000; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        wait_at(36);
        push4(8'hC6, 8'h90, 8'h80, 8'h78);
        upd_data = 16'h789C; upd_dp = 4'b1000; upd_valid = 1'b1;
        chk("ready_low_while_pending", upd_ready, 1'b0);
        wait_at(48);
        chk("ready_returns_b", upd_ready, 1'b1);
        step();
        chk("b_accepted", upd_ready, 1'b0);
        upd_valid = 1'b0;
        drain();
        mon_en = 1'b0;

        // Brightness duty
        brightness = 2'd1; step(); step();
        count_on(32, cnt); chk("duty_b1", cnt, 8);
        brightness = 2'd2; step(); step();
        count_on(32, cnt); chk("duty_b2", cnt, 16);
        brightness = 2'd0; step(); step();
        count_on(32, cnt); chk("duty_b0", cnt, 0);
        brightness = 2'd3; step(); step();
        count_on(32, cnt); chk("duty_b3", cnt, 24);

        // Blank takes effect within one cycle
        g = 0;
        while (tcyc % 4 != 1 && g < 8) begin step(); g++; end
        k = tcyc;
        blank = 1'b1;
        @(negedge clk_sys);
        chk("pre_blank_sel", SEG_SELECT_OUT, 4'hF & ~(4'b1 << ((k / 4) % 4)));
        chk("pre_blank_hex", HEX_OUT, hex_b[(k / 4) % 4]);
        @(negedge clk_sys);
        chk("blank_sel", SEG_SELECT_OUT, 4'hF);
        chk("blank_hex", HEX_OUT, 8'hFF);
        step();
        count_on(16, cnt); chk("blank_dark", cnt, 0);
        blank = 1'b0;

        // Reset with an update pending
        upd_data = 16'hFFFF; upd_dp = 4'hF; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        chk("pending_before_rst", upd_ready, 1'b0);
        rst_n = 1'b0;
        step(); step();
        @(negedge clk_sys);
        chk("rst2_ready", upd_ready, 1'b1);
        chk("rst2_sel", SEG_SELECT_OUT, 4'hF);
        step();
        rst_n = 1'b1;
        push4(8'hC0, Z, Z, Z);
        push4(8'hC0, Z, Z, Z);
        mon_en = 1'b1;
        @(negedge clk_sys);
        chk("rst2_ready_after", upd_ready, 1'b1);

        // Leading-zero patterns
        wait_at(18);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push4(8'h92, 8'hFF, 8'hFF, 8'hFF);
`else
        push4(8'h92, 8'hC0, 8'hC0, 8'hC0);
`endif
        upd_data = 16'h0005; upd_dp = 4'b0000; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        wait_at(34);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        push4(8'h92, 8'hC0, 8'h40, 8'hFF);
`else
        push4(8'h92, 8'hC0, 8'h40, 8'hC0);
`endif
        upd_data = 16'h0005; upd_dp = 4'b0100; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        drain();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Parametrised successor to the fixed 4-digit mouse-coordinate display driver.
- Drives an N-digit common-anode multiplexed seven-segment display from a packed hex word.
- Uses a valid/ready update port and applies accepted updates only at frame boundaries, so frames never tear.
- Adds per-digit decimal points, PWM brightness and global blanking; sits in clk_sys beside the mouse and processor subsystems.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 50000, clk_sys cycles per digit slot (>=2); 50000 gives 1 kHz at 50 MHz.
- BRIGHT_W, 4, width of the brightness control.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  reset; synchronous and active-low.
- upd_valid  in  1  update request.
- upd_ready  out  1  update port can accept.
- upd_data  in  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0] = rightmost.
- upd_dp  in  NUM_DIGITS  decimal-point enables, 1 = lit.
- brightness  in  BRIGHT_W  duty level; 0 = dark, all-ones = full on.
- blank  in  1  force all anodes off.
- SEG_SELECT_OUT  out  NUM_DIGITS  anode selects, active-low, one-hot-low.
- HEX_OUT  out  8  cathodes, active-low; [6:0] = gfedcba, [7] = dp.

Behaviour:
- Reset (rst_n low at a clk_sys edge) clears the following:
  - SEG_SELECT_OUT all ones, HEX_OUT 8'hFF, upd_ready 1.
  - Active and pending registers 0; pending flag 0.
  - Slot counter 0, digit index 0, PWM counter 0.
- Reset mid-operation discards any pending update.
- Slot counter counts 0..SCAN_DIV-1 and wraps; slot_tick asserts when count == SCAN_DIV-1.
- Digit index advances on slot_tick and wraps NUM_DIGITS-1 -> 0.
- frame_end = slot_tick && index == NUM_DIGITS-1.
- Update handshake:
  - upd_ready = !pending.
  - Transfer occurs on upd_valid && upd_ready; it captures upd_data and upd_dp into the pending register and sets pending.
  - On frame_end with pending set: copy pending to active, clear pending; upd_ready rises the next cycle.
  - Transfer in the same cycle as frame_end: the data is buffered and applied at the following frame_end, never mid-frame.
  - upd_valid while upd_ready = 0: ignored; the source must hold it.
- PWM counter is free-running and increments every cycle, BRIGHT_W bits, wrapping.
- Digit is on when !blank && (brightness == all-ones || pwm_cnt < brightness).
- Outputs are registered with 1-cycle latency from index/active/pwm state.
  - Digit on: SEG_SELECT_OUT = ~(1 << index); HEX_OUT = {~dp[index], seg(active nibble[index])}.
  - Digit off: SEG_SELECT_OUT all ones, HEX_OUT 8'hFF.
- Ghosting guard: on the cycle after slot_tick, outputs are forced to the off state for one cycle.
- Segment code (gfedcba, active-low): 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E.

Optional Feature:
- Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is blanked when its nibble and all higher nibbles are 0 and none of their dp bits are set. Blanked means anode off and HEX_OUT 8'hFF for that slot. Digit 0 is always displayed.
- Undefined: every digit is displayed.

Decomposition:
- Package seg7_pkg holds:
  - constant SEG_LUT[16] of 7-bit active-low codes;
  - constants SEG_OFF = 8'hFF and ANODE_OFF;
  - typedef nibble_t = logic [3:0].
- Sub-module seg7_scan_timer (params SCAN_DIV, NUM_DIGITS) owns the slot counter, digit index, slot_tick and frame_end.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, BRIGHT_W=2):
1. Hold rst_n low 3 cycles, release -> SEG_SELECT_OUT = 4'hF and HEX_OUT = 8'hFF during reset; upd_ready = 1; then digits scan 1110, 1101, 1011, 0111 with HEX_OUT = 8'hC0, brightness = 3.
2. upd_data = 16'h12AF, upd_dp = 4'b0100 mid-frame -> upd_ready drops for 1+ cycles; old values persist until frame_end; next frame shows digit0 = 8'h8E, 1 = 8'h88, 2 = 8'h24 (dp lit), 3 = 8'hF9.
3. Second upd_valid while pending -> not accepted; accepted the cycle after upd_ready returns; applied one frame later.
4. brightness = 1 -> anode low exactly 1 of every 4 pwm cycles; brightness = 0 -> SEG_SELECT_OUT stays 4'hF; blank = 1 -> all off within 1 cycle.
5. Assert rst_n low with an update pending -> pending cleared, active = 0, upd_ready = 1 after release.
6. With SEG7_LEADING_ZERO_BLANK_EN and upd_data = 16'h0005 -> digits 3..1 output 8'hFF, digit0 = 8'h92; set upd_dp[2] -> digit2 shows 8'h40, digit3 stays blank.
